// File: rtl/ftdi_deframer_pkg.sv
// Shared constants and FSM state encoding for the FT245 receive deframer.
package ftdi_deframer_pkg;

    localparam logic [7:0] SYNC_BYTE = 8'hA5;
    localparam logic [7:0] ACK_BYTE  = 8'h06;
    localparam logic [7:0] NAK_BYTE  = 8'h15;

    typedef enum logic [2:0] {
        ST_HUNT    = 3'd0,
        ST_LEN     = 3'd1,
        ST_PAYLOAD = 3'd2,
        ST_CHK     = 3'd3,
        ST_ACK     = 3'd4
    } state_e;

    // A frame length is usable only if it is non-zero and a whole number of words.
    function automatic logic len_legal(input logic [7:0] len, input int unsigned word_bytes);
        return (len != 8'd0) && ((len & 8'(word_bytes - 1)) == 8'd0);
    endfunction

endpackage

// File: rtl/ftdi_word_packer.sv
// Shifts payload bytes into a little-endian word and holds it in a valid/ready output register.
module ftdi_word_packer #(
    parameter int WORD_BYTES = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    byte_valid_i,
    input  logic [7:0]              byte_data_i,
    input  logic                    byte_last_i,
    input  logic                    flush_i,
    output logic [8*WORD_BYTES-1:0] out_data_o,
    output logic                    out_valid_o,
    output logic                    out_last_o,
    input  logic                    out_ready_i
);

    localparam int W = 8 * WORD_BYTES;

    logic [1:0]   idx_q, idx_d;
    logic [W-1:0] buf_q, buf_d;
    logic [W-1:0] data_q, data_d;
    logic         valid_q, valid_d;
    logic         last_q, last_d;

    // The caller only pushes a byte while the output register is empty, so a
    // completed word never collides with a word still waiting for out_ready.
    always_comb begin
        idx_d   = idx_q;
        buf_d   = buf_q;
        data_d  = data_q;
        valid_d = valid_q;
        last_d  = last_q;
        if (valid_q && out_ready_i) begin
            valid_d = 1'b0;
            last_d  = 1'b0;
        end
        if (flush_i) begin
            idx_d = 2'd0;
        end else if (byte_valid_i) begin
            for (int i = 0; i < WORD_BYTES; i++) begin
                if (idx_q == 2'(i)) buf_d[i*8 +: 8] = byte_data_i;
            end
            if (idx_q == 2'(WORD_BYTES - 1)) begin
                data_d  = buf_d;
                valid_d = 1'b1;
                last_d  = byte_last_i;
                idx_d   = 2'd0;
            end else begin
                idx_d = idx_q + 2'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idx_q   <= 2'd0;
            buf_q   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            idx_q   <= idx_d;
            buf_q   <= buf_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            last_q  <= last_d;
        end
    end

    assign out_data_o  = data_q;
    assign out_valid_o = valid_q;
    assign out_last_o  = last_q;

endmodule

// File: rtl/ftdi_rx_deframer.sv
// FT245 receive deframer: SYNC/LEN/payload[/CHK] frames to packed words plus ACK/NAK byte.
// Define FTDI_DEFRAMER_CHECKSUM_EN to expect and verify the trailing XOR checksum byte.
module ftdi_rx_deframer
    import ftdi_deframer_pkg::*;
#(
    parameter int WORD_BYTES     = 2,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [7:0]              rx_data,
    input  logic                    rx_valid,
    output logic                    rx_ready,
    output logic [7:0]              tx_data,
    output logic                    tx_valid,
    input  logic                    tx_ready,
    output logic [8*WORD_BYTES-1:0] out_data,
    output logic                    out_valid,
    output logic                    out_last,
    input  logic                    out_ready,
    output logic                    frame_ok,
    output logic                    frame_err,
    output logic [15:0]             err_count,
    output state_e                  state
);

    localparam int             TW        = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0]  TOUT_LAST = TW'(TIMEOUT_CYCLES - 1);

    // Every interface transfers on a cycle where valid && ready; valid, once
    // raised by a producer here, holds with stable data until that cycle.
    state_e        state_q, state_d;
    logic [7:0]    rem_q, rem_d;
    logic [TW-1:0] tout_q, tout_d;
    logic [7:0]    tx_data_q, tx_data_d;
    logic          tx_valid_q, tx_valid_d;
    logic          ok_q, ok_d;
    logic          err_q, err_d;
    logic [15:0]   cnt_q, cnt_d;
`ifdef FTDI_DEFRAMER_CHECKSUM_EN
    logic [7:0]    chk_q, chk_d;
`endif

    logic rx_fire, rx_idle, err_inc, push, push_last, flush;

    always_comb begin
        rx_ready = 1'b0;
        if (!rst) begin
            case (state_q)
                ST_HUNT, ST_LEN, ST_CHK: rx_ready = 1'b1;
                ST_PAYLOAD:              rx_ready = !out_valid;
                default:                 rx_ready = 1'b0;
            endcase
        end
    end

    assign rx_fire = rx_valid && rx_ready;
    assign rx_idle = rx_ready && !rx_valid;

    always_comb begin
        state_d    = state_q;
        rem_d      = rem_q;
        tout_d     = tout_q;
        tx_data_d  = tx_data_q;
        tx_valid_d = tx_valid_q;
        ok_d       = 1'b0;
        err_d      = 1'b0;
        err_inc    = 1'b0;
        push       = 1'b0;
        push_last  = 1'b0;
        flush      = 1'b0;
`ifdef FTDI_DEFRAMER_CHECKSUM_EN
        chk_d      = chk_q;
`endif
        case (state_q)
            ST_HUNT: begin
                if (rx_fire && rx_data == SYNC_BYTE) begin
                    state_d = ST_LEN;
                    tout_d  = '0;
                end
            end
            ST_LEN: begin
                if (rx_fire) begin
                    tout_d = '0;
                    if (!len_legal(rx_data, WORD_BYTES)) begin
                        tx_data_d  = NAK_BYTE;
                        tx_valid_d = 1'b1;
                        err_d      = 1'b1;
                        err_inc    = 1'b1;
                        state_d    = ST_ACK;
                    end else begin
                        rem_d   = rx_data;
`ifdef FTDI_DEFRAMER_CHECKSUM_EN
                        chk_d   = rx_data;
`endif
                        state_d = ST_PAYLOAD;
                    end
                end
            end
            ST_PAYLOAD: begin
                if (rx_fire) begin
                    tout_d    = '0;
                    push      = 1'b1;
                    push_last = (rem_q == 8'd1);
                    rem_d     = rem_q - 8'd1;
`ifdef FTDI_DEFRAMER_CHECKSUM_EN
                    chk_d     = chk_q ^ rx_data;
                    if (rem_q == 8'd1) state_d = ST_CHK;
`else
                    if (rem_q == 8'd1) begin
                        tx_data_d  = ACK_BYTE;
                        tx_valid_d = 1'b1;
                        ok_d       = 1'b1;
                        state_d    = ST_ACK;
                    end
`endif
                end
            end
`ifdef FTDI_DEFRAMER_CHECKSUM_EN
            ST_CHK: begin
                if (rx_fire) begin
                    tout_d     = '0;
                    tx_valid_d = 1'b1;
                    state_d    = ST_ACK;
                    if (rx_data == chk_q) begin
                        tx_data_d = ACK_BYTE;
                        ok_d      = 1'b1;
                    end else begin
                        tx_data_d = NAK_BYTE;
                        err_d     = 1'b1;
                        err_inc   = 1'b1;
                    end
                end
            end
`endif
            ST_ACK: begin
                if (tx_valid_q && tx_ready) begin
                    tx_valid_d = 1'b0;
                    state_d    = ST_HUNT;
                end
            end
            default: state_d = ST_HUNT;
        endcase

        // Only host silence counts; a stalled sample FIFO drops rx_ready and freezes the count.
        if ((state_q == ST_LEN || state_q == ST_PAYLOAD || state_q == ST_CHK) && rx_idle) begin
            if (tout_q == TOUT_LAST) begin
                tout_d  = '0;
                err_d   = 1'b1;
                err_inc = 1'b1;
                flush   = 1'b1;
                state_d = ST_HUNT;
            end else begin
                tout_d = tout_q + TW'(1);
            end
        end

        cnt_d = cnt_q;
        if (err_inc && cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_HUNT;
            rem_q      <= 8'd0;
            tout_q     <= '0;
            tx_data_q  <= 8'd0;
            tx_valid_q <= 1'b0;
            ok_q       <= 1'b0;
            err_q      <= 1'b0;
            cnt_q      <= 16'd0;
`ifdef FTDI_DEFRAMER_CHECKSUM_EN
            chk_q      <= 8'd0;
`endif
        end else begin
            state_q    <= state_d;
            rem_q      <= rem_d;
            tout_q     <= tout_d;
            tx_data_q  <= tx_data_d;
            tx_valid_q <= tx_valid_d;
            ok_q       <= ok_d;
            err_q      <= err_d;
            cnt_q      <= cnt_d;
`ifdef FTDI_DEFRAMER_CHECKSUM_EN
            chk_q      <= chk_d;
`endif
        end
    end

    ftdi_word_packer #(.WORD_BYTES(WORD_BYTES)) u_packer (
        .clk          (clk),
        .rst          (rst),
        .byte_valid_i (push),
        .byte_data_i  (rx_data),
        .byte_last_i  (push_last),
        .flush_i      (flush),
        .out_data_o   (out_data),
        .out_valid_o  (out_valid),
        .out_last_o   (out_last),
        .out_ready_i  (out_ready)
    );

    assign tx_data   = tx_data_q;
    assign tx_valid  = tx_valid_q;
    assign frame_ok  = ok_q;
    assign frame_err = err_q;
    assign err_count = cnt_q;
    assign state     = state_q;

endmodule

// File: tb/tb_ftdi_rx_deframer.sv
// Scoreboard bench for ftdi_rx_deframer: frame-level model feeds expected queues, monitors pop them.
module tb_ftdi_rx_deframer;
  import ftdi_deframer_pkg::*;

  localparam int WB = 2;
  localparam int TO = 64;
  localparam int W  = 8 * WB;
`ifdef FTDI_DEFRAMER_CHECKSUM_EN
  localparam bit CHK_EN = 1'b1;
`else
  localparam bit CHK_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [7:0]   rx_data = 8'd0;
  logic         rx_valid = 1'b0;
  logic         rx_ready;
  logic [7:0]   tx_data;
  logic         tx_valid;
  logic         tx_ready = 1'b0;
  logic [W-1:0] out_data;
  logic         out_valid;
  logic         out_last;
  logic         out_ready = 1'b0;
  logic         frame_ok;
  logic         frame_err;
  logic [15:0]  err_count;
  state_e       state;

  ftdi_rx_deframer #(.WORD_BYTES(WB), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .out_data(out_data), .out_valid(out_valid), .out_last(out_last), .out_ready(out_ready),
    .frame_ok(frame_ok), .frame_err(frame_err), .err_count(err_count), .state(state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // ---------------- scoreboard state ----------------
  logic [W:0]   exp_word_q[$];   // {last, data}
  logic [7:0]   exp_tx_q[$];
  logic [17:0]  exp_pulse_q[$];  // {ok, err, err_count}
  logic [7:0]   payload[$];
  int           n_cmp = 0;
  int           n_fail = 0;
  int           model_err = 0;
  bit           stall = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic flag(input string name);
    n_cmp++;
    n_fail++;
    $display("FAIL %s at %0t", name, $time);
  endtask

  // ---------------- responders ----------------
  always begin
    @(posedge clk);
    #1;
    out_ready = stall ? 1'b0 : ($urandom_range(0, 3) != 0);
    tx_ready  = tx_valid && ($urandom_range(0, 2) == 0);
  end

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (!rst) begin
      if (out_valid && out_ready) begin
        if (exp_word_q.size() == 0) flag("unexpected_word");
        else check("out_word", {31'd0, out_last, out_data}, {15'd0, exp_word_q.pop_front()});
      end
      if (tx_valid && tx_ready) begin
        if (exp_tx_q.size() == 0) flag("unexpected_tx");
        else check("tx_byte", {24'd0, tx_data}, {24'd0, exp_tx_q.pop_front()});
      end
      if (frame_ok || frame_err) begin
        if (exp_pulse_q.size() == 0) flag("unexpected_pulse");
        else begin
          logic [17:0] e;
          e = exp_pulse_q.pop_front();
          check("frame_pulse", {30'd0, frame_ok, frame_err}, {30'd0, e[17:16]});
          check("err_count", {16'd0, err_count}, {16'd0, e[15:0]});
        end
      end
    end
  end

  // ---------------- drivers ----------------
  task automatic send_byte(input logic [7:0] b);
    int n;
    int g;
    n = 0;
    rx_data  = b;
    rx_valid = 1'b1;
    forever begin
      @(negedge clk);
      if (rx_ready) begin
        @(posedge clk);
        #1;
        break;
      end
      n++;
      if (n > 3000) begin
        flag("rx_accept_timeout");
        break;
      end
    end
    rx_valid = 1'b0;
    g = $urandom_range(0, 2);
    repeat (g) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic fill_payload(input int n);
    payload.delete();
    for (int i = 0; i < n; i++) payload.push_back(8'($urandom_range(0, 255)));
  endtask

  task automatic push_err();
    model_err++;
    exp_pulse_q.push_back({2'b01, 16'(model_err)});
  endtask

  // Full frame from the global payload queue; bad_chk corrupts the checksum byte.
  task automatic send_frame(input logic [7:0] len, input bit bad_chk);
    logic [7:0]   chk;
    logic [W-1:0] w;
    int           nw;
    if (len == 0 || (int'(len) % WB) != 0) begin
      exp_tx_q.push_back(8'h15);
      push_err();
      send_byte(8'hA5);
      send_byte(len);
      return;
    end
    chk = len;
    for (int i = 0; i < int'(len); i++) chk = chk ^ payload[i];
    nw = int'(len) / WB;
    for (int wi = 0; wi < nw; wi++) begin
      for (int b = 0; b < WB; b++) w[8*b +: 8] = payload[wi*WB + b];
      exp_word_q.push_back({(wi == nw - 1), w});
    end
    if (CHK_EN && bad_chk) begin
      exp_tx_q.push_back(8'h15);
      push_err();
    end else begin
      exp_tx_q.push_back(8'h06);
      exp_pulse_q.push_back({2'b10, 16'(model_err)});
    end
    send_byte(8'hA5);
    send_byte(len);
    for (int i = 0; i < int'(len); i++) send_byte(payload[i]);
    if (CHK_EN) send_byte(bad_chk ? (chk ^ 8'h01) : chk);
  endtask

  // Frame that goes silent after k payload bytes; only whole words survive.
  task automatic send_timeout_frame(input logic [7:0] len, input int k);
    logic [W-1:0] w;
    for (int wi = 0; wi < k / WB; wi++) begin
      for (int b = 0; b < WB; b++) w[8*b +: 8] = payload[wi*WB + b];
      exp_word_q.push_back({1'b0, w});
    end
    push_err();
    send_byte(8'hA5);
    send_byte(len);
    for (int i = 0; i < k; i++) send_byte(payload[i]);
    repeat (TO + 30) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_word_q.size() + exp_tx_q.size() + exp_pulse_q.size()) != 0 && n < 4000) begin
      @(posedge clk);
      n++;
    end
    if (n >= 4000) flag("drain_timeout");
    repeat (5) @(posedge clk);
    #1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int kind;
    int len;
    logic [7:0] junk;

    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_rx_ready", {31'd0, rx_ready}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_tx_valid", {31'd0, tx_valid}, 32'd0);
    check("rst_err_count", {16'd0, err_count}, 32'd0);
    check("rst_out_data", {16'd0, out_data}, 32'd0);
    check("rst_state", 32'(state), 32'(ST_HUNT));
    check("hunt_rx_ready", {31'd0, rx_ready}, 32'd1);
    @(posedge clk);
    #1;

    // good frame, then the same frame with a bad checksum
    payload = '{8'h11, 8'h22, 8'h33, 8'h44};
    send_frame(8'd4, 1'b0);
    drain();
    if (CHK_EN) begin
      payload = '{8'h11, 8'h22, 8'h33, 8'h44};
      send_frame(8'd4, 1'b1);
      drain();
    end

    // leading junk then an odd length
    send_byte(8'h00);
    send_byte(8'hFF);
    payload.delete();
    send_frame(8'd3, 1'b0);
    drain();

    // silent host mid-payload, then recovery
    payload = '{8'h11, 8'h22};
    send_timeout_frame(8'd2, 1);
    drain();
    payload = '{8'h11, 8'h22, 8'h33, 8'h44};
    send_frame(8'd4, 1'b0);
    drain();

    // downstream stall far longer than the timeout
    stall = 1'b1;
    out_ready = 1'b0;
    payload = '{8'h11, 8'h22, 8'h33, 8'h44};
    fork
      send_frame(8'd4, 1'b0);
      begin
        repeat (TO + 40) @(posedge clk);
        @(negedge clk);
        check("stall_rx_ready", {31'd0, rx_ready}, 32'd0);
        check("stall_out_valid", {31'd0, out_valid}, 32'd1);
        check("stall_out_data", {16'd0, out_data}, 32'h2211);
        check("stall_no_err", {31'd0, frame_err}, 32'd0);
        @(posedge clk);
        #1;
        stall = 1'b0;
      end
    join
    drain();

    // randomized mix of frame types
    for (int f = 0; f < 30; f++) begin
      kind = $urandom_range(0, 9);
      if ($urandom_range(0, 3) == 0) begin
        junk = 8'($urandom_range(0, 255));
        if (junk == 8'hA5) junk = 8'h5A;
        send_byte(junk);
      end
      if (kind == 0) begin
        len = ($urandom_range(0, 1) == 0) ? 0 : 2 * $urandom_range(0, 6) + 1;
        payload.delete();
        send_frame(8'(len), 1'b0);
      end else if (kind == 1) begin
        len = 2 * $urandom_range(1, 6);
        fill_payload(len);
        send_timeout_frame(8'(len), $urandom_range(0, len - 1));
      end else begin
        len = 2 * $urandom_range(1, 8);
        fill_payload(len);
        send_frame(8'(len), ($urandom_range(0, 3) == 0));
      end
    end
    drain();

    // reset in the middle of a payload with a word parked in the output register
    stall = 1'b1;
    out_ready = 1'b0;
    send_byte(8'hA5);
    send_byte(8'h04);
    send_byte(8'h11);
    send_byte(8'h22);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("mid_rst_rx_ready", {31'd0, rx_ready}, 32'd0);
    check("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("mid_rst_out_last", {31'd0, out_last}, 32'd0);
    check("mid_rst_out_data", {16'd0, out_data}, 32'd0);
    check("mid_rst_tx_valid", {31'd0, tx_valid}, 32'd0);
    check("mid_rst_tx_data", {24'd0, tx_data}, 32'd0);
    check("mid_rst_pulses", {30'd0, frame_ok, frame_err}, 32'd0);
    check("mid_rst_err_count", {16'd0, err_count}, 32'd0);
    check("mid_rst_state", 32'(state), 32'(ST_HUNT));
    @(posedge clk);
    #1;
    rst = 1'b0;
    stall = 1'b0;
    model_err = 0;

    payload = '{8'hAA, 8'hBB};
    send_frame(8'd2, 1'b0);
    drain();

    check("words_left", exp_word_q.size(), 32'd0);
    check("tx_left", exp_tx_q.size(), 32'd0);
    check("pulses_left", exp_pulse_q.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
